// File: rtl/svi_rr_pkg.sv
// Shared sizing helpers for the round-robin stream multiplexer.
// Imported by the arbiter and the top-level mux.
package svi_rr_pkg;

  localparam int MAX_CH = 64;

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svi_rr_mux_if.sv
// Stream handshake bundle: a producer drives valid/data/last, the consumer
// answers with ready.
interface S #(parameter int WIDTH = 8);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/svi_rr_mux_rr_pick.sv
// Combinational cyclic priority search: first requester after ptr wins,
// wrapping from N-1 back to 0.
module rr_pick
  import svi_rr_pkg::*;
#(
  parameter  int N    = 8,
  localparam int CH_W = ch_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            grant_vld
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_vld && req[idx]) begin
        grant     = CH_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svi_rr_mux.sv
// Round-robin N-to-1 stream mux with a registered output beat.
// Optional packet lock: define SVI_RR_PKT_LOCK_EN to keep a channel granted until its last beat.
module svi_rr_mux
  import svi_rr_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 8,
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  S.slave                  u_S [N_CH],
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [CH_W-1:0]  o_chan,
  input  logic             i_ready
);

  if (N_CH < 1 || N_CH > MAX_CH) begin : gBadCfg
    $error("svi_rr_mux: N_CH out of range");
  end

  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  chLast;
  logic [WIDTH-1:0] chData [N_CH];
  logic [CH_W-1:0]  grant;
  logic             grantVld;
  logic             load;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             last_q,  last_d;
  logic [CH_W-1:0]  chan_q,  chan_d;
  logic [CH_W-1:0]  ptr_q,   ptr_d;

`ifdef SVI_RR_PKT_LOCK_EN
  logic             lock_q,   lock_d;
  logic [CH_W-1:0]  lockCh_q, lockCh_d;
`endif

  assign load = !valid_q || i_ready;

  // While a packet is locked only its owner may request.
  for (genvar g = 0; g < N_CH; g++) begin : gChan
    assign chData[g] = u_S[g].data;
    assign chLast[g] = u_S[g].last;
`ifdef SVI_RR_PKT_LOCK_EN
    assign req[g] = u_S[g].valid && (!lock_q || (lockCh_q == CH_W'(g)));
`else
    assign req[g] = u_S[g].valid;
`endif
    always_comb begin
      u_S[g].ready = i_rst_n && load && grantVld && (grant == CH_W'(g));
    end
  end

  rr_pick #(.N(N_CH)) uPick (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_vld (grantVld)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
`ifdef SVI_RR_PKT_LOCK_EN
    lock_d   = lock_q;
    lockCh_d = lockCh_q;
`endif
    if (load) begin
      if (grantVld) begin
        valid_d = 1'b1;
        data_d  = chData[grant];
        last_d  = chLast[grant];
        chan_d  = grant;
        ptr_d   = grant;
`ifdef SVI_RR_PKT_LOCK_EN
        lock_d   = !chLast[grant];
        lockCh_d = grant;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Reset parks ptr on the last channel so channel 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= CH_W'(N_CH - 1);
`ifdef SVI_RR_PKT_LOCK_EN
      lock_q   <= 1'b0;
      lockCh_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
`ifdef SVI_RR_PKT_LOCK_EN
      lock_q   <= lock_d;
      lockCh_q <= lockCh_d;
`endif
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_chan  = chan_q;

endmodule

// File: tb/tb_svi_rr_mux.sv
// Self-checking bench for svi_rr_mux (8 channels, 8-bit payload); the lock
// scenario is compiled in only when SVI_RR_PKT_LOCK_EN is defined.
module tb_svi_rr_mux;

  localparam int NCH = 8;
  localparam int W   = 8;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       sinkRdy;
  logic [7:0] vld;
  logic [7:0] lst;
  logic [7:0] rdy;
  logic [7:0] acc;
  logic [4:0] seq    [NCH];
  logic [4:0] expSeq [NCH];

  logic       oValid;
  logic       oLast;
  logic [7:0] oData;
  logic [2:0] oChan;

  beat_t expQ [$];
  beat_t expBeat;
  int    compared   = 0;
  int    mismatched = 0;

  always #5 clk = ~clk;

  S #(.WIDTH(W)) sIf [NCH] ();

  // Each producer presents {channel, sequence number} as its payload.
  for (genvar g = 0; g < NCH; g++) begin : gBind
    assign sIf[g].valid = vld[g];
    assign sIf[g].last  = lst[g];
    assign sIf[g].data  = {3'(g), seq[g]};
    assign rdy[g]       = sIf[g].ready;
  end

  svi_rr_mux #(.N_CH(NCH), .WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .u_S     (sIf),
    .o_valid (oValid),
    .o_data  (oData),
    .o_last  (oLast),
    .o_chan  (oChan),
    .i_ready (sinkRdy)
  );

  task automatic tick();
    @(negedge clk);
    acc = vld & rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (acc[i]) seq[i] = seq[i] + 5'd1;
  endtask

  task automatic push(input int ch, input logic l);
    expQ.push_back('{ch: 3'(ch), data: {3'(ch), expSeq[ch]}, last: l});
    expSeq[ch] = expSeq[ch] + 5'd1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; vld = 8'hFF; lst = 8'h00; sinkRdy = 1'b1;
    repeat (3) begin
      tick();
      compared++;
      if ({oValid, oData, oLast, oChan} !== 13'd0 || rdy !== 8'h00) begin
        mismatched++;
        $display("[TB] FAIL reset_state: got valid %b data %h last %b chan %0d ready %b, required all zero",
                 oValid, oData, oLast, oChan, rdy);
      end
    end
    rstN = 1'b1;
    #1;
    compared++;
    if (rdy !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL first_ready: got %b, required 00000001", rdy);
    end
    push(0, 1'b0);
    tick();
    compared++;
    if (oValid !== 1'b1 || oChan !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL first_beat: got valid %b chan %0d, required valid 1 chan 0", oValid, oChan);
    end
    vld = 8'h00;
    #1;
    if (oValid && sinkRdy) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL reset_beat: got chan %0d data %h, required no beat", oChan, oData);
      end else begin
        expBeat = expQ.pop_front();
        if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
          mismatched++;
          $display("[TB] FAIL reset_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                   oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
        end
      end
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_drain: got valid %b pending %0d, required valid 0 pending 0", oValid, expQ.size());
    end
  endtask

  task automatic test_fairness();
    rstN = 1'b0; vld = 8'h00;
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) push(i % NCH, 1'b0);
    vld = 8'hFF; sinkRdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      compared++;
      if (oValid !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL fair_valid: cycle %0d got valid %b, required 1", c, oValid);
      end
      if (c == 9) vld = 8'h00;
      #1;
      if (oValid && sinkRdy) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL fair_beat: got chan %0d data %h, required no beat", oChan, oData);
        end else begin
          expBeat = expQ.pop_front();
          if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
            mismatched++;
            $display("[TB] FAIL fair_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                     oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
          end
        end
      end
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL fair_drain: got valid %b pending %0d, required valid 0 pending 0", oValid, expQ.size());
    end
  endtask

  task automatic test_backpressure();
    push(2, 1'b0); push(3, 1'b0); push(4, 1'b0); push(5, 1'b0);
    push(6, 1'b0); push(7, 1'b0); push(0, 1'b0); push(1, 1'b0);
    vld = 8'hFF; sinkRdy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      sinkRdy = !(c >= 2 && c <= 5);
      if (c == 11) vld = 8'h00;
      #1;
      if (!sinkRdy && expQ.size() != 0) begin
        compared++;
        if (rdy !== 8'h00 || oValid !== 1'b1 || oChan !== expQ[0].ch || oData !== expQ[0].data) begin
          mismatched++;
          $display("[TB] FAIL stall_hold: got valid %b chan %0d data %h ready %b, required valid 1 chan %0d data %h ready 0",
                   oValid, oChan, oData, rdy, expQ[0].ch, expQ[0].data);
        end
      end
      if (oValid && sinkRdy) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL bp_beat: got chan %0d data %h, required no beat", oChan, oData);
        end else begin
          expBeat = expQ.pop_front();
          if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
            mismatched++;
            $display("[TB] FAIL bp_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                     oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
          end
        end
      end
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL bp_drain: got valid %b pending %0d, required valid 0 pending 0", oValid, expQ.size());
    end
  endtask

  task automatic test_sparse();
    logic [7:0] heldData;
    push(6, 1'b0); push(2, 1'b0); push(6, 1'b0); push(2, 1'b0);
    vld = 8'h40; sinkRdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vld = (c == 3) ? 8'h00 : 8'h44;
      #1;
      if (oValid && sinkRdy) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL sparse_beat: got chan %0d data %h, required no beat", oChan, oData);
        end else begin
          expBeat = expQ.pop_front();
          if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
            mismatched++;
            $display("[TB] FAIL sparse_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                     oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
          end
        end
      end
    end
    heldData = {3'd2, expSeq[2] - 5'd1};
    repeat (2) begin
      tick();
      compared++;
      if (oValid !== 1'b0 || oChan !== 3'd2 || oData !== heldData) begin
        mismatched++;
        $display("[TB] FAIL idle_hold: got valid %b chan %0d data %h, required valid 0 chan 2 data %h",
                 oValid, oChan, oData, heldData);
      end
    end
    vld = 8'h0C;
    #1;
    compared++;
    if (rdy !== 8'h08) begin
      mismatched++;
      $display("[TB] FAIL ptr_kept: got ready %b, required 00001000", rdy);
    end
    push(3, 1'b0); push(2, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      if (c == 1) vld = 8'h00;
      #1;
      if (oValid && sinkRdy) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL ptr_beat: got chan %0d data %h, required no beat", oChan, oData);
        end else begin
          expBeat = expQ.pop_front();
          if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
            mismatched++;
            $display("[TB] FAIL ptr_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                     oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
          end
        end
      end
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL sparse_drain: got valid %b pending %0d, required valid 0 pending 0", oValid, expQ.size());
    end
  endtask

`ifdef SVI_RR_PKT_LOCK_EN
  task automatic test_lock();
    push(3, 1'b0); push(3, 1'b0); push(3, 1'b1); push(4, 1'b0);
    vld = 8'h18; lst = 8'h00; sinkRdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      lst[3] = (c == 1);
      if (c == 2) begin
        vld[3] = 1'b0;
        lst[3] = 1'b0;
      end
      if (c == 3) vld = 8'h00;
      #1;
      if (c < 2) begin
        compared++;
        if (rdy !== 8'h08) begin
          mismatched++;
          $display("[TB] FAIL lock_ready: cycle %0d got ready %b, required 00001000", c, rdy);
        end
      end
      if (oValid && sinkRdy) begin
        compared++;
        if (expQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL lock_beat: got chan %0d data %h, required no beat", oChan, oData);
        end else begin
          expBeat = expQ.pop_front();
          if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
            mismatched++;
            $display("[TB] FAIL lock_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                     oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
          end
        end
      end
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL lock_drain: got valid %b pending %0d, required valid 0 pending 0", oValid, expQ.size());
    end
  endtask
`endif

  task automatic test_midreset();
    push(5, 1'b0);
    vld = 8'h60; lst = 8'h00; sinkRdy = 1'b0;
    tick();
    compared++;
    if (oValid !== 1'b1 || oChan !== expQ[0].ch || oData !== expQ[0].data) begin
      mismatched++;
      $display("[TB] FAIL mid_held: got valid %b chan %0d data %h, required valid 1 chan %0d data %h",
               oValid, oChan, oData, expQ[0].ch, expQ[0].data);
    end
    rstN = 1'b0;
    #1;
    compared++;
    if (rdy !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL mid_rst_ready: got %b, required 00000000", rdy);
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || oChan !== 3'd0 || oData !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL mid_rst_out: got valid %b chan %0d data %h, required valid 0 chan 0 data 00",
               oValid, oChan, oData);
    end
    expQ.delete();
    rstN = 1'b1; vld = 8'h21; sinkRdy = 1'b1;
    push(0, 1'b0);
    #1;
    compared++;
    if (rdy !== 8'h01) begin
      mismatched++;
      $display("[TB] FAIL mid_restart: got ready %b, required 00000001", rdy);
    end
    tick();
    vld = 8'h00;
    #1;
    if (oValid && sinkRdy) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL mid_beat: got chan %0d data %h, required no beat", oChan, oData);
      end else begin
        expBeat = expQ.pop_front();
        if (oChan !== expBeat.ch || oData !== expBeat.data || oLast !== expBeat.last) begin
          mismatched++;
          $display("[TB] FAIL mid_beat: got chan %0d data %h last %b, required chan %0d data %h last %b",
                   oChan, oData, oLast, expBeat.ch, expBeat.data, expBeat.last);
        end
      end
    end
    tick();
    compared++;
    if (oValid !== 1'b0 || expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL mid_drain: got valid %b pending %0d, required valid 0 pending 0", oValid, expQ.size());
    end
  endtask

  initial begin
    rstN = 1'b0; sinkRdy = 1'b1; vld = 8'h00; lst = 8'h00; acc = 8'h00;
    for (int i = 0; i < NCH; i++) begin
      seq[i]    = 5'd0;
      expSeq[i] = 5'd0;
    end
    test_reset();
    test_fairness();
    test_backpressure();
    test_sparse();
`ifdef SVI_RR_PKT_LOCK_EN
    test_lock();
`endif
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, required completion within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/svi_rr_mux.md
# svi_rr_mux

Round-robin N-to-1 stream multiplexer. It takes an unpacked array of stream SVI instances on its input side and presents one registered output stream with the winning channel index. Per-channel `ready` is driven back into each interface array element from a generate loop. It is the parametrised successor of the fixed-size scalar-member-assignment blocks: channel count, data width and handshake are all generic. It sits between per-source producers and a single shared sink.

## Interface
Parameters:
- `N_CH`, default 8: number of input channels; legal range is 1..64.
- `WIDTH`, default 8: payload width in bits.

Ports:
- `i_clk`, input, 1: the single clock. All state is updated on its rising edge.
- `i_rst_n`, input, 1: reset, synchronous and active-low.
- `u_S`, interface array `S [N_CH]`: input channels. The module reads `valid`, `data[WIDTH-1:0]` and `last`, and drives `ready`.
- `o_valid`, output, 1: output beat is valid.
- `o_data`, output, WIDTH: output payload.
- `o_last`, output, 1: copy of the granted beat's `last`.
- `o_chan`, output, CH_W: index of the source channel of the current output beat.
- `i_ready`, input, 1: sink accepts the output beat when `o_valid && i_ready`.

## Operation
- `load = !o_valid || i_ready`. The output register accepts a new beat only when `load` is high.
- Eligible channels are those with `u_S[g].valid` high. The arbiter picks the first eligible channel, searching cyclically from `ptr+1`.
- `u_S[g].ready = load && grant_vld && (grant == g)`. This is combinational, driven by an `always_comb` inside a generate loop. At most one `ready` is high in any cycle.
- When a channel beat is accepted (`valid && ready` on channel g):
  - `o_data`, `o_last` and `o_chan` take g's values.
  - `o_valid` goes to 1.
  - `ptr` is set to g.
- When `load` is high and no channel is eligible:
  - `o_valid` goes to 0.
  - `o_data`, `o_last` and `o_chan` hold their values.
  - `ptr` is unchanged.
- When `o_valid && !i_ready`, all outputs hold and every `ready` is 0.
- The round-robin pointer is `ptr`, CH_W bits wide. The search wraps from index N_CH-1 to 0. If the pick arithmetic is done in CH_W+1 bits, it is reduced modulo N_CH.
- With `N_CH == 1`, CH_W is 1 and `o_chan` is always 0. The block then behaves as a one-deep pipeline register.

## Timing
- Reset values: `o_valid` 0, `o_data` 0, `o_last` 0, `o_chan` 0.
- Internal reset values: `ptr` is N_CH-1, so channel 0 has first priority; the lock state is cleared.
- Latency: a channel beat accepted at edge k appears on the output after edge k, i.e. one cycle.
- Throughput: one beat per cycle while `i_ready` is held high.
- A sink may drain the current beat and the arbiter may accept a new one on the same edge. There is no bubble.
- If `i_rst_n` is low at an edge, reset wins over every other action. Any in-flight output beat is dropped without being presented to the sink.
- `ready` is never asserted while `i_rst_n` is low.
- The block adds no combinational path from `i_ready` to `o_*`. The only combinational path is from `i_ready` to `u_S[*].ready`, through `load`.

## Configuration
- `SVI_RR_PKT_LOCK_EN` defined: packet lock.
  - After accepting a beat with `last == 0` from channel g, only g is eligible.
  - The lock releases when a beat from g with `last == 1` is accepted.
  - While locked, if g drops `valid`, no other channel is granted: the output runs dry and `o_valid` goes to 0 once the last beat is drained.
  - Reset clears the lock.
- `SVI_RR_PKT_LOCK_EN` not defined: arbitration is per beat. `last` is only passed through to `o_last`, and no lock register is synthesised.

## Structure
- Package `svi_rr_pkg`:
  - `function automatic int ch_w(int n)`, returning `(n > 1) ? $clog2(n) : 1`.
  - `localparam int MAX_CH = 64`.
- Interface `S #(WIDTH)`: members `valid`, `ready`, `data`, `last`. It lives alongside the package file.
- Sub-module `rr_pick #(N)`:
  - Purely combinational.
  - Inputs: `req[N]` and `ptr`.
  - Outputs: `grant` (CH_W bits) and `grant_vld`.
  - It holds the cyclic priority search, so the top module contains only the registers, the lock and the generate loop for `ready`.

## Test plan
- Reset: hold `i_rst_n` low for 3 cycles with all valids high. Required: all outputs are 0 and all `ready` are 0. On release, the first beat comes from channel 0 and `o_chan == 0` one cycle later.
- Fairness: N_CH=8 and all 8 channels valid continuously, with `i_ready` at 1. Required: `o_chan` sequence 0,1,...,7,0,1 with `o_valid` high every cycle.
- Backpressure: deassert `i_ready` for 4 cycles mid-stream. Required: `o_data` and `o_chan` are stable, no channel `ready` is asserted, and the sequence resumes with no lost or duplicated beat.
- Sparse requests: only channels 2 and 6 valid, with `ptr` at 6. Required: grants go to 2, 6, 2. With no requests, `o_valid` is 0 and `ptr` is unchanged.
- Lock (macro defined): channel 3 sends 3 beats with `last` = 0,0,1 while channel 4 is valid throughout. Required: `o_chan` reads 3,3,3,4, and channel 4's `ready` is held low during channel 3's packet.
- Mid-stream reset: assert `i_rst_n` low while `o_valid == 1` and the lock is held. Required: `o_valid` is 0 after the edge, the lock is cleared, and arbitration restarts at channel 0.
